bin_to_bcd_serial: RTL and testbench
====================================

Name: bin_to_bcd_serial

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It produces the packed BCD digits that feed the board's per-digit 7-segment decoders. Typical source is a MIPS register, PC or counter value shown on the display. Start/busy/done handshake; the last result is held stable for the display between conversions.

Parameters:
DATA_WIDTH, 16, width of unsigned binary input.
DIGITS, 5, number of BCD output digits; must satisfy DIGITS >= ceil(DATA_WIDTH*log10(2)) (16->5, 32->10); elaboration error otherwise.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
Start  input  1  conversion request, sampled only in IDLE.
Data  input  DATA_WIDTH  unsigned binary value, captured on the accepting edge.
BCD  output  4*DIGITS  packed result, digit 0 (units) in [3:0], digit i in [4i+3:4i].
Busy  output  1  high while a conversion is in progress.
Done  output  1  one-cycle pulse when BCD has just been updated.

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-high (reset).
- Reset (async assert, any state): state=IDLE, BCD=0, Busy=0, Done=0, internal shift/scratch/counter=0.
- States: IDLE, SHIFT.
- IDLE: on edge with Start=1, capture Data into shift reg, clear scratch digits, bit counter=0, Busy<=1, go SHIFT. Start=0: stay, Busy=0.
- SHIFT, each edge:
  - every scratch digit >=5 gets +3 (combinational, all digits in parallel);
  - then {scratch, shift} shifts left 1, MSB of shift reg enters scratch digit 0 LSB;
  - counter++.
- On the edge performing shift number DATA_WIDTH:
  - BCD <= final scratch value (corrected and shifted in the same edge);
  - Done<=1, Busy<=0, go IDLE.
- Latency: Start accepted at edge k -> BCD valid and Done=1 in the cycle after edge k+DATA_WIDTH (DATA_WIDTH cycles). Busy=1 for exactly DATA_WIDTH cycles.
- Done is high for exactly one cycle; cleared on the next edge unless another conversion finishes there (impossible for DATA_WIDTH>=1).
- Start while Busy=1: ignored; not queued.
- Start=1 in the Done cycle: state is IDLE, so it is accepted; back-to-back throughput is one result per DATA_WIDTH+1 cycles.
- Data changes during SHIFT: no effect, because Data is captured at acceptance.
- BCD output changes only on the completion edge or reset; it never shows partial results.
- Every output nibble is always in 0..9, so the downstream decoders never receive codes 10-15.
- Reset mid-conversion: conversion aborted, BCD=0, no Done pulse.
- Counter width: clog2(DATA_WIDTH+1).

Decomposition:
- Shared package bcd_pkg: state enum (IDLE, SHIFT); constant BCD_DIGIT_W=4; function min_digits(width) used for the DIGITS legality check.
- One sub-module bcd_add3: 4-bit combinational corrector (in>=5 ? in+3 : in), instantiated DIGITS times via generate.

Test Plan:
- Reset, then Start with Data=0 -> after 16 cycles Done=1 for 1 cycle, BCD=20'h00000, Busy was high for exactly 16 cycles.
- Data=16'd65535 -> BCD=20'h65535; Data=16'd12345 -> BCD=20'h12345; Data=16'd9 -> BCD=20'h00009, nibble 1 stays 0.
- Data=1234 started, Start pulsed again with Data=999 at cycle 5 -> ignored; result 20'h01234, single Done pulse.
- Start held high continuously with Data sequence 10, 20 -> second conversion accepted in the Done cycle of the first; results 20'h00010 then 20'h00020, Done pulses 17 cycles apart.
- Convert 4321, then Start 8888 and assert reset at cycle 8 -> BCD=0 immediately (async), Busy=0, no Done; a fresh conversion of 7 yields 20'h00007.
- DATA_WIDTH=32, DIGITS=10, Data=32'hFFFFFFFF -> BCD=40'h4294967295 after 32 cycles; random sweep of 1000 values checked against a reference model; all nibbles <=9.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial binary-to-BCD converter.
//   state_t      : converter FSM states (IDLE, SHIFT)
//   BCD_DIGIT_W  : bits per BCD digit
//   min_digits() : decimal digits needed to show any unsigned value of a given bit width
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned BCD_DIGIT_W = 4;

  // ceil(width * log10(2)), done with scaled integers so it stays a constant function.
  function automatic int unsigned min_digits(input int unsigned width);
    longint unsigned scaled;
    scaled = 64'(width) * 64'd301029996;
    return 32'((scaled + 64'd999999999) / 64'd1000000000);
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more so that the
// following left shift carries correctly into the next decimal digit.
//   digit     : scratch digit before correction
//   corrected : digit after the conditional +3
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  assign corrected = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// The last result is held on BCD between conversions for the display decoders.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   Start : conversion request, only sampled while idle
//   Data  : unsigned binary value, captured on the accepting edge
//   BCD   : packed result, digit 0 (units) in [3:0]
//   Busy  : high while a conversion is in progress
//   Done  : one-cycle pulse when BCD has just been updated
module bin_to_bcd_serial
  import bcd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIGITS     = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          Start,
  input  logic [DATA_WIDTH-1:0]         Data,
  output logic [BCD_DIGIT_W*DIGITS-1:0] BCD,
  output logic                          Busy,
  output logic                          Done
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  if (DATA_WIDTH < 1) begin : gen_width_check
    $error("bin_to_bcd_serial: DATA_WIDTH must be at least 1");
  end

  if (DIGITS < min_digits(DATA_WIDTH)) begin : gen_digits_check
    $error("bin_to_bcd_serial: DIGITS too small to represent DATA_WIDTH-bit values");
  end

  state_t                  state;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [BCD_W-1:0]        scratch;
  logic [BCD_W-1:0]        corrected;
  logic [BCD_W-1:0]        scratch_next;
  logic [CNT_W-1:0]        bit_cnt;
  // The top digit's MSB is shifted out; with DIGITS sized correctly it is always zero.
  logic                    unused_top_bit;

  for (genvar g = 0; g < DIGITS; g++) begin : gen_add3
    bcd_add3 u_add3 (
      .digit     (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .corrected (corrected[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Correct all digits in parallel, then shift the next binary MSB into digit 0.
  assign scratch_next   = {corrected[BCD_W-2:0], shift_reg[DATA_WIDTH-1]};
  assign unused_top_bit = corrected[BCD_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      BCD       <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            shift_reg <= Data;
            scratch   <= '0;
            bit_cnt   <= '0;
            Busy      <= 1'b1;
            state     <= SHIFT;
          end else begin
            Busy <= 1'b0;
          end
        end
        SHIFT: begin
          shift_reg <= shift_reg << 1;
          scratch   <= scratch_next;
          bit_cnt   <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_CNT) begin
            // Publish only the finished value so the display never sees partial digits.
            BCD   <= scratch_next;
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Scoreboard bench for bin_to_bcd_serial: a 16-bit/5-digit and a 32-bit/10-digit instance.
module tb_bin_to_bcd_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // 16-bit instance
  logic        rst16 = 1'b0;
  logic        start16 = 1'b0;
  logic [15:0] data16 = '0;
  logic [19:0] bcd16;
  logic        busy16, done16;

  // 32-bit instance
  logic        rst32 = 1'b0;
  logic        start32 = 1'b0;
  logic [31:0] data32 = '0;
  logic [39:0] bcd32;
  logic        busy32, done32;

  bin_to_bcd_serial #(.DATA_WIDTH(16), .DIGITS(5)) dut16 (
    .clk   (clk),
    .reset (rst16),
    .Start (start16),
    .Data  (data16),
    .BCD   (bcd16),
    .Busy  (busy16),
    .Done  (done16)
  );

  bin_to_bcd_serial #(.DATA_WIDTH(32), .DIGITS(10)) dut32 (
    .clk   (clk),
    .reset (rst32),
    .Start (start32),
    .Data  (data32),
    .BCD   (bcd32),
    .Busy  (busy32),
    .Done  (done32)
  );

  logic [79:0] exp16_q[$];
  logic [79:0] exp32_q[$];

  // Reference: repeated division by ten, one decimal digit per nibble.
  function automatic logic [79:0] ref_bcd(input longint unsigned v);
    logic [79:0] r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 20; i++) begin
      r[4*i +: 4] = 4'(x % 64'd10);
      x = x / 64'd10;
    end
    return r;
  endfunction

  function automatic int nibbles_ok(input logic [79:0] v);
    int ok;
    ok = 1;
    for (int i = 0; i < 20; i++) if (v[4*i +: 4] > 4'd9) ok = 0;
    return ok;
  endfunction

  task automatic check_val(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  logic [19:0] last16 = '0;
  int          busy_cnt16 = 0;
  logic        prev_done16 = 1'b0;

  always @(negedge clk) begin
    if (rst16) begin
      last16 = '0;
      busy_cnt16 = 0;
      prev_done16 = 1'b0;
    end else begin
      if (busy16) busy_cnt16++;
      if (done16) begin
        check_int("done16_single_cycle", int'(prev_done16), 0);
        if (exp16_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done16_unexpected: got Done with BCD %h, expected no Done", bcd16);
        end else begin
          check_val("bcd16", 80'(bcd16), exp16_q.pop_front());
        end
        check_int("busy16_cycles", busy_cnt16, 16);
        check_int("bcd16_nibbles", nibbles_ok(80'(bcd16)), 1);
        busy_cnt16 = 0;
        last16 = bcd16;
      end else begin
        check_val("bcd16_hold", 80'(bcd16), 80'(last16));
      end
      prev_done16 = done16;
    end
  end

  logic [39:0] last32 = '0;
  int          busy_cnt32 = 0;
  logic        prev_done32 = 1'b0;

  always @(negedge clk) begin
    if (rst32) begin
      last32 = '0;
      busy_cnt32 = 0;
      prev_done32 = 1'b0;
    end else begin
      if (busy32) busy_cnt32++;
      if (done32) begin
        check_int("done32_single_cycle", int'(prev_done32), 0);
        if (exp32_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done32_unexpected: got Done with BCD %h, expected no Done", bcd32);
        end else begin
          check_val("bcd32", 80'(bcd32), exp32_q.pop_front());
        end
        check_int("busy32_cycles", busy_cnt32, 32);
        check_int("bcd32_nibbles", nibbles_ok(80'(bcd32)), 1);
        busy_cnt32 = 0;
        last32 = bcd32;
      end else begin
        check_val("bcd32_hold", 80'(bcd32), 80'(last32));
      end
      prev_done32 = done32;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle16();
    int n = 0;
    @(negedge clk);
    while (busy16 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL idle16_timeout: Busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic wait_done16(output int at_cyc);
    int n = 0;
    at_cyc = -1;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (done16) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) begin
      total++;
      bad++;
      $display("FAIL done16_timeout: no Done within %0d cycles, expected one", n);
    end
  endtask

  task automatic convert16(input logic [15:0] v);
    wait_idle16();
    start16 = 1'b1;
    data16  = v;
    exp16_q.push_back(ref_bcd(64'(v)));
    @(negedge clk);
    start16 = 1'b0;
    data16  = 16'($urandom);  // must not affect the running conversion
  endtask

  task automatic convert32(input logic [31:0] v);
    int n = 0;
    @(negedge clk);
    while (busy32 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL idle32_timeout: Busy still 1 after %0d cycles, expected 0", n);
    end
    start32 = 1'b1;
    data32  = v;
    exp32_q.push_back(ref_bcd(64'(v)));
    @(negedge clk);
    start32 = 1'b0;
    data32  = $urandom;
  endtask

  // ---------------- drivers ----------------
  task automatic run16();
    int t1, t2;
    rst16 = 1'b1;
    repeat (2) @(negedge clk);
    check_val("reset16_bcd", 80'(bcd16), 80'(0));
    check_int("reset16_busy", int'(busy16), 0);
    check_int("reset16_done", int'(done16), 0);
    #1 rst16 = 1'b0;

    convert16(16'd0);
    convert16(16'd65535);
    convert16(16'd12345);
    convert16(16'd9);

    // Start while busy must be ignored.
    convert16(16'd1234);
    repeat (5) @(negedge clk);
    start16 = 1'b1;
    data16  = 16'd999;
    @(negedge clk);
    start16 = 1'b0;

    // Start held high: second request accepted in the Done cycle of the first.
    wait_idle16();
    start16 = 1'b1;
    data16  = 16'd10;
    exp16_q.push_back(ref_bcd(64'd10));
    @(negedge clk);
    data16 = 16'd20;
    wait_done16(t1);
    exp16_q.push_back(ref_bcd(64'd20));
    @(negedge clk);
    start16 = 1'b0;
    wait_done16(t2);
    check_int("done16_spacing", t2 - t1, 17);

    // Reset in the middle of a conversion aborts it without a Done.
    convert16(16'd4321);
    wait_idle16();
    start16 = 1'b1;
    data16  = 16'd8888;
    @(negedge clk);
    start16 = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst16 = 1'b1;
    #1;
    check_val("midreset16_bcd", 80'(bcd16), 80'(0));
    check_int("midreset16_busy", int'(busy16), 0);
    check_int("midreset16_done", int'(done16), 0);
    @(negedge clk);
    #1 rst16 = 1'b0;
    convert16(16'd7);

    for (int i = 0; i < 400; i++) convert16(16'($urandom));
    wait_idle16();
    repeat (3) @(negedge clk);
    check_int("q16_drained", exp16_q.size(), 0);
  endtask

  task automatic run32();
    int n = 0;
    rst32 = 1'b1;
    repeat (2) @(negedge clk);
    check_val("reset32_bcd", 80'(bcd32), 80'(0));
    check_int("reset32_busy", int'(busy32), 0);
    #1 rst32 = 1'b0;

    convert32(32'hFFFF_FFFF);
    convert32(32'd0);
    convert32(32'd1_000_000_000);
    for (int i = 0; i < 1000; i++) convert32($urandom);
    @(negedge clk);
    while ((busy32 || exp32_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_int("q32_drained", exp32_q.size(), 0);
    check_val("final32_max_digits", 80'(nibbles_ok(80'(bcd32))), 80'(1));
  endtask

  initial begin
    fork
      run16();
      run32();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
